// File: rtl/muldiv_hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Op encodings, FSM states and helpers for the HI/LO mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MUL   = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int DIV_ITERS = 32;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_hilo_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_unit_if
// Brief    : Execute-stage request/response bundle for the HI/LO unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_hilo_unit_if;
    logic        Op_Valid;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Intreq;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;

    modport master (output Op_Valid, Op, A, B, Intreq,
                    input  HI, LO, Busy, Done);
    modport slave  (input  Op_Valid, Op, A, B, Intreq,
                    output HI, LO, Busy, Done);
endinterface
`default_nettype wire

// File: rtl/muldiv_hilo_unit_div_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_core
// Brief    : Unsigned radix-2 restoring divider, one quotient bit per step.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_core (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        step,
    input  wire logic [31:0] dividend,
    input  wire logic [31:0] divisor,
    output logic [31:0]      quotient,
    output logic [31:0]      remainder
);
    // Upper half: partial remainder; lower half: dividend bits shifting out
    // while quotient bits shift in.
    logic [63:0] r_rq;
    logic [31:0] r_div;
    logic [63:0] w_shift;
    logic [32:0] w_trial;

    assign w_shift = {r_rq[62:0], 1'b0};
    // The bit shifted out of the top keeps the 33-bit trial exact for
    // divisors above 2^31.
    assign w_trial = {r_rq[63], w_shift[63:32]} - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq  <= 64'd0;
            r_div <= 32'd0;
        end else if (start) begin
            r_rq  <= {32'd0, dividend};
            r_div <= divisor;
        end else if (step) begin
            r_rq  <= w_trial[32] ? w_shift : {w_trial[31:0], w_shift[31:1], 1'b1};
        end
    end

    assign quotient  = r_rq[31:0];
    assign remainder = r_rq[63:32];

endmodule
`default_nettype wire

// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_unit
// Brief    : Multi-cycle mul/div responder owning the architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = DIV_ITERS + 1
) (
    input  wire logic         Clk,
    input  wire logic         Clr_n,
    muldiv_hilo_unit_if.slave md
);
    localparam logic [5:0] C_MUL_CNT = 6'(MUL_LAT);
    localparam logic [5:0] C_DIV_CNT = 6'(DIV_LAT);

    md_state_e   r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_op_a, r_op_b;
    logic        r_op_signed, r_busy, r_done;

    logic        w_accept, w_div_start, w_div_step;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [31:0] w_q_mag, w_r_mag, w_div_lo, w_div_hi;

    assign w_accept    = (r_state == ST_IDLE) && md.Op_Valid && !md.Intreq;
    assign w_div_start = w_accept && ((md.Op == MD_DIV) || (md.Op == MD_DIVU));
    // Last DIV cycle (r_cnt==1) is the commit/sign-fix cycle, not a step.
    assign w_div_step  = (r_state == ST_DIV) && (r_cnt != 6'd1) && !md.Intreq;

    div_iter_core u_div (
        .clk       (Clk),
        .rst_n     (Clr_n),
        .start     (w_div_start),
        .step      (w_div_step),
        .dividend  ((md.Op == MD_DIV) ? abs32(md.A) : md.A),
        .divisor   ((md.Op == MD_DIV) ? abs32(md.B) : md.B),
        .quotient  (w_q_mag),
        .remainder (w_r_mag)
    );

    // Sign-extended 64x64 product truncated to 64 bits is the exact
    // signed (or unsigned) 32x32 product.
    assign w_ext_a = r_op_signed ? {{32{r_op_a[31]}}, r_op_a} : {32'd0, r_op_a};
    assign w_ext_b = r_op_signed ? {{32{r_op_b[31]}}, r_op_b} : {32'd0, r_op_b};
    assign w_prod  = w_ext_a * w_ext_b;

    always_comb begin
        w_div_lo = w_q_mag;
        w_div_hi = w_r_mag;
        if (r_op_b == 32'd0) begin
            w_div_lo = (r_op_signed && r_op_a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            w_div_hi = r_op_a;
        end else if (r_op_signed) begin
            if (r_op_a[31] ^ r_op_b[31]) w_div_lo = ~w_q_mag + 32'd1;
            if (r_op_a[31])              w_div_hi = ~w_r_mag + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 6'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_op_signed <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (md.Op)
                            MD_MULT, MD_MULTU, MD_MUL, MD_DIV, MD_DIVU: begin
                                r_op_a      <= md.A;
                                r_op_b      <= md.B;
                                r_op_signed <= (md.Op == MD_MULT) || (md.Op == MD_MUL) ||
                                               (md.Op == MD_DIV);
                                r_busy      <= 1'b1;
                                if (w_div_start) begin
                                    r_cnt   <= C_DIV_CNT;
                                    r_state <= ST_DIV;
                                end else begin
                                    r_cnt   <= C_MUL_CNT;
                                    r_state <= ST_MUL;
                                end
                            end
                            MD_MTHI: r_hi <= md.A;
                            MD_MTLO: r_lo <= md.A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md.Intreq) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 6'd1) begin
                        if (r_state == ST_MUL) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else begin
                            r_hi <= w_div_hi;
                            r_lo <= w_div_lo;
                        end
                        r_state <= ST_IDLE;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
    assign md.Busy = r_busy;
    assign md.Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo_unit
// Brief    : Directed and randomized self-checking bench for muldiv_hilo_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic clr_n;
    muldiv_hilo_unit_if md();

    muldiv_hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
        .Clk   (clk),
        .Clr_n (clr_n),
        .md    (md)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} computed with plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, rm;
        logic [63:0] r, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (op)
            MD_MULT, MD_MUL: r = 64'(sa * sb);
            MD_MULTU:        r = {32'd0, a} * {32'd0, b};
            MD_DIVU:         r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MD_DIV: begin
                if (b == 0) r = {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    qv = 64'(q);
                    rv = 64'(rm);
                    r  = {rv[31:0], qv[31:0]};
                end
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Model: cycles of Busy remaining plus the result waiting to land.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;
    bit          m_done;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_done = 0; m_pend = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                if (md.Intreq) m_left = 0;
                else if (m_left == 1) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1;
                    m_left = 0;
                end else m_left--;
            end else if (md.Op_Valid && !md.Intreq) begin
                case (md.Op)
                    MD_MTHI: m_hi = md.A;
                    MD_MTLO: m_lo = md.A;
                    MD_MULT, MD_MULTU, MD_MUL: begin
                        m_pend = model_result(md.Op, md.A, md.B);
                        m_left = MUL_LAT;
                    end
                    MD_DIV, MD_DIVU: begin
                        m_pend = model_result(md.Op, md.A, md.B);
                        m_left = DIV_LAT;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (clr_n) begin
            check("cyc_busy", 32'(md.Busy), 32'(m_left > 0));
            check("cyc_done", 32'(md.Done), 32'(m_done));
            check("cyc_hi",   md.HI, m_hi);
            check("cyc_lo",   md.LO, m_lo);
        end
    end

    // Called at a falling edge; the request is seen on the following rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.Op_Valid = 1'b1; md.Op = op; md.A = a; md.B = b;
        @(negedge clk);
        md.Op_Valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, input bit noise);
        cyc = 0;
        while (md.Busy && cyc < 200) begin
            cyc++;
            if (noise) begin
                md.Op_Valid = ($urandom_range(0, 3) == 0);
                md.Op       = 3'($urandom_range(0, 6));
                md.A        = $urandom;
                md.Intreq   = ($urandom_range(0, 40) == 0);
            end
            @(negedge clk);
        end
        md.Op_Valid = 1'b0;
        md.Intreq   = 1'b0;
        if (cyc >= 200) begin
            total++; bad++;
            $display("FAIL busy_timeout: Busy still high after %0d cycles", cyc);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    int cyc;

    initial begin
        md.Op_Valid = 1'b0; md.Op = 3'd0; md.A = 32'd0; md.B = 32'd0; md.Intreq = 1'b0;
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi",   md.HI, 32'd0);
        check("rst_lo",   md.LO, 32'd0);
        check("rst_busy", 32'(md.Busy), 32'd0);
        check("rst_done", 32'(md.Done), 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(cyc, 1'b0);
        check("mult_busy_cycles", 32'(cyc), 32'(MUL_LAT));
        check("mult_done", 32'(md.Done), 32'd1);
        check("mult_hi", md.HI, 32'hFFFF_FFFF);
        check("mult_lo", md.LO, 32'hFFFF_FFFA);
        @(negedge clk);
        check("mult_done_once", 32'(md.Done), 32'd0);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc, 1'b0);
        check("multu_hi", md.HI, 32'hFFFF_FFFE);
        check("multu_lo", md.LO, 32'h0000_0001);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc, 1'b0);
        check("div_busy_cycles", 32'(cyc), 32'(DIV_LAT));
        check("div_lo", md.LO, 32'hFFFF_FFFD);
        check("div_hi", md.HI, 32'hFFFF_FFFF);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc, 1'b0);
        check("div_ovf_lo", md.LO, 32'h8000_0000);
        check("div_ovf_hi", md.HI, 32'h0000_0000);

        issue(MD_DIVU, 32'd5, 32'd0);
        wait_idle(cyc, 1'b0);
        check("divu_z_lo", md.LO, 32'hFFFF_FFFF);
        check("divu_z_hi", md.HI, 32'd5);

        issue(MD_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_idle(cyc, 1'b0);
        check("div_z_lo", md.LO, 32'h0000_0001);
        check("div_z_hi", md.HI, 32'hFFFF_FFFB);

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_busy", 32'(md.Busy), 32'd0);
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mthi_hi", md.HI, 32'h1234_5678);
        check("mtlo_lo", md.LO, 32'h9ABC_DEF0);

        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        md.Intreq = 1'b1;
        @(negedge clk);
        md.Intreq = 1'b0;
        check("abort_busy", 32'(md.Busy), 32'd0);
        check("abort_done", 32'(md.Done), 32'd0);
        check("abort_hi", md.HI, 32'h1234_5678);
        check("abort_lo", md.LO, 32'h9ABC_DEF0);

        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle(cyc, 1'b0);
        check("divu_lo", md.LO, 32'd14);
        check("divu_hi", md.HI, 32'd2);

        issue(MD_MULT, 32'd3, 32'd4);
        #2 clr_n = 1'b0;
        #1;
        check("async_busy", 32'(md.Busy), 32'd0);
        check("async_hi", md.HI, 32'd0);
        check("async_lo", md.LO, 32'd0);
        #1 clr_n = 1'b1;
        @(negedge clk);

        issue(MD_MTLO, 32'h77, 32'd0);
        md.Intreq = 1'b1;
        issue(MD_MTLO, 32'h55, 32'd0);
        md.Intreq = 1'b0;
        check("int_drop_lo", md.LO, 32'h77);
        check("int_drop_busy", 32'(md.Busy), 32'd0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 6)), pick_operand(), pick_operand());
            wait_idle(cyc, 1'b1);
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
